// File: rtl/cpu_int_seq_pkg.sv
// Shared types for the CPU interrupt/BRK sequencer.
// Status register layout, sequencer states, interrupt kinds and vectors.
package cpu_int_seq_pkg;

    typedef struct packed {
        logic n;
        logic v;
        logic u;
        logic b;
        logic d;
        logic i;
        logic z;
        logic c;
    } statusReg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_PCH,
        ST_PUSH_PCL,
        ST_PUSH_P,
        ST_VEC_LO,
        ST_VEC_HI,
        ST_LOAD
    } intstate_t;

    typedef enum logic [1:0] {
        INT_NONE,
        INT_BRK,
        INT_IRQ,
        INT_NMI
    } intkind_t;

    localparam logic [15:0] NMI_VEC    = 16'hFFFA;
    localparam logic [15:0] IRQ_VEC    = 16'hFFFE;
    localparam logic [7:0]  STACK_PAGE = 8'h01;

    // Status byte as pushed: U forced high, B marks a software BRK.
    function automatic logic [7:0] push_status(
        input statusReg_t s,
        input logic       brk
    );
        statusReg_t p;
        p   = s;
        p.u = 1'b1;
        p.b = brk;
        return p;
    endfunction

endpackage

// File: rtl/cpu_int_sync.sv
// Multi-bit, multi-stage synchroniser for asynchronous active-low lines.
// Every flop resets to 1 so the lines read as inactive out of reset.
module cpu_int_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [STAGES];

    // Shift the raw lines through the flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '1;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cpu_int_seq.sv
// Interrupt/BRK sequencer: arbitration, stack pushes and vector fetch.
// Optional CPU_IRQ_MASK_EN adds a per-source IRQ mask register.
module cpu_int_seq
    import cpu_int_seq_pkg::*;
#(
    parameter int NUM_IRQ     = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
`ifdef CPU_IRQ_MASK_EN
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
`endif
    input  logic [NUM_IRQ-1:0] irq_n,
    input  logic               nmi_n,
    input  logic               instr_boundary,
    input  logic               brk_req,
    input  logic               i_flag,
    input  logic [7:0]         status_in,
    input  logic [15:0]        pc_in,
    input  logic [7:0]         sp_in,
    input  logic [7:0]         bus_rdata,
    input  logic               bus_ready,
    output logic               take_int,
    output logic               busy,
    output logic [15:0]        bus_addr,
    output logic [7:0]         bus_wdata,
    output logic               bus_we,
    output logic               bus_re,
    output logic [7:0]         sp_out,
    output logic               sp_we,
    output logic [15:0]        pc_out,
    output logic               pc_load,
    output logic               set_i,
    output logic [1:0]         int_kind,
    output logic [CW-1:0]      irq_cause
);

    intstate_t          state;
    intstate_t          nxt;
    intkind_t           kind;
    statusReg_t         st_cap;
    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_act;
    logic [NUM_IRQ-1:0] mask;
    logic               nmi_s;
    logic               nmi_prev;
    logic               nmi_pend;
    logic               irq_any;
    logic               accept;
    logic               push;
    logic               enter_vlo;
    logic               brk_cap;
    logic               vec_nmi;
    logic [15:0]        vec_base;
    logic [15:0]        pc_cap;
    logic [7:0]         sp_cur;
    logic [7:0]         vec_lo;
    logic [7:0]         vec_hi;

    function automatic logic [CW-1:0] lowest(
        input logic [NUM_IRQ-1:0] v
    );
        lowest = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) lowest = CW'(i);
        end
    endfunction

    cpu_int_sync #(
        .W      (NUM_IRQ + 1),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({nmi_n, irq_n}),
        .q   ({nmi_s, irq_s})
    );

`ifdef CPU_IRQ_MASK_EN
    // Per-source enable mask; all sources enabled out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '1;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end
`else
    assign mask = '1;
`endif

    assign irq_act   = ~irq_s & mask;
    assign irq_any   = |irq_act;
    assign push      = (state == ST_PUSH_PCH) ||
                       (state == ST_PUSH_PCL) ||
                       (state == ST_PUSH_P);
    assign enter_vlo = (state == ST_PUSH_P) && bus_ready;
    assign vec_base  = vec_nmi ? NMI_VEC : IRQ_VEC;
    assign pc_out    = {vec_hi, vec_lo};
    assign int_kind  = kind;

    // NMI edge detect; a new edge wins over the vector-entry clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_prev <= 1'b1;
            nmi_pend <= 1'b0;
        end else begin
            nmi_prev <= nmi_s;
            if (enter_vlo && nmi_pend) nmi_pend <= 1'b0;
            if (nmi_prev && !nmi_s)    nmi_pend <= 1'b1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    // Next state, arbitration and bus drive.
    always_comb begin
        nxt       = state;
        take_int  = 1'b0;
        accept    = 1'b0;
        busy      = (state != ST_IDLE);
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_addr  = 16'h0000;
        bus_wdata = 8'h00;
        pc_load   = 1'b0;
        set_i     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                take_int = instr_boundary && !brk_req &&
                           (nmi_pend || (irq_any && !i_flag));
                accept   = brk_req || take_int;
                if (accept) nxt = ST_PUSH_PCH;
            end
            ST_PUSH_PCH: begin
                bus_we    = 1'b1;
                bus_addr  = {STACK_PAGE, sp_cur};
                bus_wdata = pc_cap[15:8];
                if (bus_ready) nxt = ST_PUSH_PCL;
            end
            ST_PUSH_PCL: begin
                bus_we    = 1'b1;
                bus_addr  = {STACK_PAGE, sp_cur};
                bus_wdata = pc_cap[7:0];
                if (bus_ready) nxt = ST_PUSH_P;
            end
            ST_PUSH_P: begin
                bus_we    = 1'b1;
                bus_addr  = {STACK_PAGE, sp_cur};
                bus_wdata = push_status(st_cap, brk_cap);
                if (bus_ready) nxt = ST_VEC_LO;
            end
            ST_VEC_LO: begin
                bus_re   = 1'b1;
                bus_addr = vec_base;
                if (bus_ready) nxt = ST_VEC_HI;
            end
            ST_VEC_HI: begin
                bus_re   = 1'b1;
                bus_addr = {vec_base[15:1], 1'b1};
                if (bus_ready) nxt = ST_LOAD;
            end
            ST_LOAD: begin
                pc_load = 1'b1;
                set_i   = 1'b1;
                nxt     = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Capture context at acceptance; freeze vector choice at VEC_LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_cap    <= '0;
            st_cap    <= '0;
            brk_cap   <= 1'b0;
            kind      <= INT_NONE;
            irq_cause <= '0;
            vec_nmi   <= 1'b0;
        end else begin
            if (accept) begin
                pc_cap  <= pc_in;
                st_cap  <= status_in;
                brk_cap <= brk_req;
                if (brk_req) begin
                    kind <= INT_BRK;
                end else if (nmi_pend) begin
                    kind <= INT_NMI;
                end else begin
                    kind      <= INT_IRQ;
                    irq_cause <= lowest(irq_act);
                end
            end
            if (enter_vlo) begin
                vec_nmi <= nmi_pend;
                if (nmi_pend) kind <= INT_NMI;
            end
        end
    end

    // Working stack pointer and its one-cycle update strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_cur <= '0;
            sp_out <= '0;
            sp_we  <= 1'b0;
        end else begin
            sp_we <= 1'b0;
            if (accept) begin
                sp_cur <= sp_in;
            end else if (push && bus_ready) begin
                sp_cur <= sp_cur - 8'd1;
                sp_out <= sp_cur - 8'd1;
                sp_we  <= 1'b1;
            end
        end
    end

    // Vector bytes latched from the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_lo <= '0;
            vec_hi <= '0;
        end else begin
            if (state == ST_VEC_LO && bus_ready) vec_lo <= bus_rdata;
            if (state == ST_VEC_HI && bus_ready) vec_hi <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_cpu_int_seq.sv
// Directed self-checking bench for cpu_int_seq.
// Define CPU_IRQ_MASK_EN to also exercise the IRQ mask register.
module tb_cpu_int_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq_n = 4'hF;
    logic        nmi_n = 1'b1;
    logic        instr_boundary = 1'b0;
    logic        brk_req = 1'b0;
    logic        i_flag = 1'b0;
    logic [7:0]  status_in = 8'h00;
    logic [15:0] pc_in = 16'h0000;
    logic [7:0]  sp_in = 8'h00;
    logic [7:0]  bus_rdata;
    logic        bus_ready = 1'b1;
    logic        take_int;
    logic        busy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [7:0]  sp_out;
    logic        sp_we;
    logic [15:0] pc_out;
    logic        pc_load;
    logic        set_i;
    logic [1:0]  int_kind;
    logic [1:0]  irq_cause;
`ifdef CPU_IRQ_MASK_EN
    logic        mask_we = 1'b0;
    logic [3:0]  mask_wdata = 4'hF;
`endif

    int total = 0;
    int bad = 0;

    logic [15:0] wa [64];
    logic [7:0]  wd [64];
    int          wcount = 0;
    int          spwe_cnt = 0;

    cpu_int_seq #(
        .NUM_IRQ     (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef CPU_IRQ_MASK_EN
        .mask_we        (mask_we),
        .mask_wdata     (mask_wdata),
`endif
        .irq_n          (irq_n),
        .nmi_n          (nmi_n),
        .instr_boundary (instr_boundary),
        .brk_req        (brk_req),
        .i_flag         (i_flag),
        .status_in      (status_in),
        .pc_in          (pc_in),
        .sp_in          (sp_in),
        .bus_rdata      (bus_rdata),
        .bus_ready      (bus_ready),
        .take_int       (take_int),
        .busy           (busy),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_we         (bus_we),
        .bus_re         (bus_re),
        .sp_out         (sp_out),
        .sp_we          (sp_we),
        .pc_out         (pc_out),
        .pc_load        (pc_load),
        .set_i          (set_i),
        .int_kind       (int_kind),
        .irq_cause      (irq_cause)
    );

    always #5 clk = ~clk;

    // Vector ROM: NMI -> 9080, IRQ/BRK -> 1234.
    always_comb begin
        bus_rdata = 8'h00;
        case (bus_addr)
            16'hFFFA: bus_rdata = 8'h80;
            16'hFFFB: bus_rdata = 8'h90;
            16'hFFFE: bus_rdata = 8'h34;
            16'hFFFF: bus_rdata = 8'h12;
            default:  bus_rdata = 8'h00;
        endcase
    end

    // Log completed stack writes and sp strobes.
    always @(posedge clk) begin
        if (!rst && bus_we && bus_ready && wcount < 64) begin
            wa[wcount] = bus_addr;
            wd[wcount] = bus_wdata;
            wcount = wcount + 1;
        end
        if (sp_we) spwe_cnt = spwe_cnt + 1;
    end

    task automatic wait_load(output int n);
        n = 1;
        while (!pc_load && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, bus_we, bus_re, bus_addr, bus_wdata, sp_out, sp_we,
             pc_out, pc_load, set_i, int_kind, irq_cause, take_int}
            !== '0) begin
            bad++;
            $display("FAIL reset_vals busy=%b we=%b re=%b a=%h kind=%0d",
                     busy, bus_we, bus_re, bus_addr, int_kind);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_brk;
        int n, w0, s0;
        sp_in = 8'hFD; pc_in = 16'hC123; status_in = 8'h00;
        bus_ready = 1'b1; w0 = wcount; s0 = spwe_cnt;
        brk_req = 1'b1;
        @(negedge clk);
        brk_req = 1'b0;
        wait_load(n);
        total++;
        if (n !== 6) begin
            bad++; $display("FAIL brk_latency got=%0d exp=6", n);
        end
        total++;
        if ({pc_out, set_i, busy, int_kind} !== {16'h1234, 1'b1, 1'b1, 2'd1}) begin
            bad++;
            $display("FAIL brk_load pc=%h set_i=%b busy=%b kind=%0d exp pc=1234 kind=1",
                     pc_out, set_i, busy, int_kind);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL brk_idle busy=%b exp=0", busy);
        end
        total++;
        if (wcount - w0 !== 3 ||
            {wa[w0], wd[w0], wa[w0+1], wd[w0+1], wa[w0+2], wd[w0+2]} !==
            {16'h01FD, 8'hC1, 16'h01FC, 8'h23, 16'h01FB, 8'h30}) begin
            bad++;
            $display("FAIL brk_pushes n=%0d %h=%h %h=%h %h=%h exp 01FD=C1 01FC=23 01FB=30",
                     wcount - w0, wa[w0], wd[w0], wa[w0+1], wd[w0+1],
                     wa[w0+2], wd[w0+2]);
        end
        total++;
        if (sp_out !== 8'hFA || spwe_cnt - s0 !== 3) begin
            bad++;
            $display("FAIL brk_sp sp=%h we=%0d exp sp=FA we=3", sp_out, spwe_cnt - s0);
        end
    endtask

    task automatic test_irq;
        int n, w0;
        sp_in = 8'h01; pc_in = 16'h8000; status_in = 8'hC3;
        i_flag = 1'b0; irq_n = 4'b1011; w0 = wcount;
        repeat (4) @(negedge clk);
        instr_boundary = 1'b1;
        #1;
        total++;
        if (take_int !== 1'b1) begin
            bad++; $display("FAIL irq_take got=%b exp=1", take_int);
        end
        @(negedge clk);
        instr_boundary = 1'b0;
        wait_load(n);
        total++;
        if ({irq_cause, int_kind, pc_out} !== {2'd2, 2'd2, 16'h1234}) begin
            bad++;
            $display("FAIL irq_seq cause=%0d kind=%0d pc=%h exp cause=2 kind=2 pc=1234",
                     irq_cause, int_kind, pc_out);
        end
        @(negedge clk);
        total++;
        if ({wa[w0], wd[w0], wa[w0+1], wd[w0+1], wa[w0+2], wd[w0+2]} !==
            {16'h0101, 8'h80, 16'h0100, 8'h00, 16'h01FF, 8'hE3}) begin
            bad++;
            $display("FAIL irq_pushes %h=%h %h=%h %h=%h exp 0101=80 0100=00 01FF=E3",
                     wa[w0], wd[w0], wa[w0+1], wd[w0+1], wa[w0+2], wd[w0+2]);
        end
        total++;
        if (sp_out !== 8'hFE) begin
            bad++; $display("FAIL irq_sp_wrap sp=%h exp=FE", sp_out);
        end
        i_flag = 1'b1;
        instr_boundary = 1'b1;
        #1;
        total++;
        if (take_int !== 1'b0) begin
            bad++; $display("FAIL irq_masked_take got=%b exp=0", take_int);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL irq_masked_busy got=%b exp=0", busy);
        end
        instr_boundary = 1'b0;
        irq_n = 4'hF;
        i_flag = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_nmi_hijack;
        int n, w0, s0;
        sp_in = 8'hFD; pc_in = 16'hC123; status_in = 8'h00;
        bus_ready = 1'b1; w0 = wcount; s0 = spwe_cnt;
        brk_req = 1'b1;
        @(negedge clk);
        brk_req = 1'b0;
        @(negedge clk);
        nmi_n = 1'b0;
        @(negedge clk);
        bus_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus_we, bus_addr, bus_wdata} !== {1'b1, 16'h01FB, 8'h30} ||
            spwe_cnt - s0 !== 2) begin
            bad++;
            $display("FAIL stall_hold we=%b a=%h d=%h spwe=%0d exp we=1 a=01FB d=30 spwe=2",
                     bus_we, bus_addr, bus_wdata, spwe_cnt - s0);
        end
        bus_ready = 1'b1;
        wait_load(n);
        total++;
        if ({pc_out, int_kind} !== {16'h9080, 2'd3}) begin
            bad++;
            $display("FAIL hijack_vec pc=%h kind=%0d exp pc=9080 kind=3", pc_out, int_kind);
        end
        @(negedge clk);
        total++;
        if (wd[w0+2] !== 8'h30 || spwe_cnt - s0 !== 3 || sp_out !== 8'hFA) begin
            bad++;
            $display("FAIL hijack_p p=%h spwe=%0d sp=%h exp p=30 spwe=3 sp=FA",
                     wd[w0+2], spwe_cnt - s0, sp_out);
        end
        instr_boundary = 1'b1;
        i_flag = 1'b1;
        repeat (3) begin
            #1;
            total++;
            if (take_int !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL nmi_cleared take=%b busy=%b exp 0 0", take_int, busy);
            end
            @(negedge clk);
        end
        instr_boundary = 1'b0;
        i_flag = 1'b0;
        nmi_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_nmi_irq;
        int n;
        nmi_n = 1'b0; irq_n = 4'b1110; i_flag = 1'b0;
        repeat (4) @(negedge clk);
        instr_boundary = 1'b1;
        #1;
        total++;
        if (take_int !== 1'b1) begin
            bad++; $display("FAIL both_take got=%b exp=1", take_int);
        end
        @(negedge clk);
        instr_boundary = 1'b0;
        i_flag = 1'b1;
        wait_load(n);
        total++;
        if ({int_kind, pc_out} !== {2'd3, 16'h9080}) begin
            bad++;
            $display("FAIL both_nmi kind=%0d pc=%h exp kind=3 pc=9080", int_kind, pc_out);
        end
        @(negedge clk);
        instr_boundary = 1'b1;
        #1;
        total++;
        if (take_int !== 1'b0) begin
            bad++; $display("FAIL both_iset take=%b exp=0", take_int);
        end
        i_flag = 1'b0;
        #1;
        total++;
        if (take_int !== 1'b1) begin
            bad++; $display("FAIL both_irq_take take=%b exp=1", take_int);
        end
        @(negedge clk);
        instr_boundary = 1'b0;
        wait_load(n);
        total++;
        if ({int_kind, irq_cause, pc_out} !== {2'd2, 2'd0, 16'h1234}) begin
            bad++;
            $display("FAIL both_irq kind=%0d cause=%0d pc=%h exp kind=2 cause=0 pc=1234",
                     int_kind, irq_cause, pc_out);
        end
        @(negedge clk);
        irq_n = 4'hF;
        nmi_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int w;
        nmi_n = 1'b0;
        sp_in = 8'hFD; pc_in = 16'hC123; status_in = 8'h00;
        brk_req = 1'b1;
        @(negedge clk);
        brk_req = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({bus_re, bus_addr} !== {1'b1, 16'hFFFB}) begin
            bad++;
            $display("FAIL mid_vechi re=%b a=%h exp re=1 a=FFFB", bus_re, bus_addr);
        end
        rst = 1'b1;
        instr_boundary = 1'b1;
        #1;
        total++;
        if ({busy, bus_we, bus_re, bus_addr, bus_wdata, sp_out, sp_we,
             pc_out, pc_load, set_i, int_kind, irq_cause, take_int}
            !== '0) begin
            bad++;
            $display("FAIL mid_reset busy=%b we=%b re=%b a=%h sp=%h take=%b",
                     busy, bus_we, bus_re, bus_addr, sp_out, take_int);
        end
        @(negedge clk);
        instr_boundary = 1'b0;
        nmi_n = 1'b1;
        rst = 1'b0;
        w = wcount;
        repeat (4) @(negedge clk);
        total++;
        if (wcount !== w || busy !== 1'b0 || sp_we !== 1'b0) begin
            bad++;
            $display("FAIL post_reset writes=%0d busy=%b exp 0 0", wcount - w, busy);
        end
    endtask

`ifdef CPU_IRQ_MASK_EN
    task automatic test_mask;
        int n;
        mask_wdata = 4'b1011; mask_we = 1'b1;
        @(negedge clk);
        mask_we = 1'b0;
        irq_n = 4'b1011; i_flag = 1'b0;
        repeat (4) @(negedge clk);
        instr_boundary = 1'b1;
        #1;
        total++;
        if (take_int !== 1'b0) begin
            bad++; $display("FAIL mask_off take=%b exp=0", take_int);
        end
        mask_wdata = 4'hF; mask_we = 1'b1;
        @(negedge clk);
        mask_we = 1'b0;
        #1;
        total++;
        if (take_int !== 1'b1) begin
            bad++; $display("FAIL mask_on take=%b exp=1", take_int);
        end
        @(negedge clk);
        instr_boundary = 1'b0;
        wait_load(n);
        total++;
        if ({int_kind, irq_cause} !== {2'd2, 2'd2}) begin
            bad++;
            $display("FAIL mask_seq kind=%0d cause=%0d exp 2 2", int_kind, irq_cause);
        end
        @(negedge clk);
        irq_n = 4'hF;
        repeat (4) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset;
        test_brk;
        test_irq;
        test_nmi_hijack;
        test_nmi_irq;
`ifdef CPU_IRQ_MASK_EN
        test_mask;
`endif
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
